midi_voice_alloc: RTL

// - Single-clock successor to the MIDI note decoder: parses a raw MIDI byte stream and allocates notes to VOICES synth voices.
// - Adds channel filtering, running status, note-on-velocity-0 as note-off, and a sustain pedal (CC64).
// - Steals the oldest voice via an age queue. All logic runs on CLOCK_25; no data-derived clocks.
// - Sits between the MIDI UART receiver and the synth engine voice array.

---
 rtl/midi_pkg.sv | 32 +++
 rtl/midi_byte_parser.sv | 77 +++++++
 rtl/midi_voice_alloc.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants for the voice allocator: status nibbles, parser states,
// controller numbers and the voice-index width helper.
package midi_pkg;

  typedef enum logic [3:0] {
    NOTE_OFF = 4'h8,
    NOTE_ON  = 4'h9,
    CC       = 4'hB,
    PRG      = 4'hC,
    BEND     = 4'hE
  } midi_status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2,
    SYSEX = 2'd3
  } parse_state_e;

  localparam logic [7:0] CC_SUSTAIN   = 8'd64;
  localparam logic [7:0] CC_SOUND_OFF = 8'd120;
  localparam logic [7:0] CC_NOTES_OFF = 8'd123;
  localparam logic [7:0] NO_NOTE      = 8'hff;

  function automatic int clogb2(input int n);
    int r;
    for (r = 0; (32'sd1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser: running status, realtime filtering and sysex skipping.
// Emits a combinational msg_valid on the byte that completes a channel message.
module midi_byte_parser
  import midi_pkg::*;
(
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       byte_valid,
  input  logic [7:0] midi_byte,
  output logic       msg_valid,
  output logic [3:0] msg_type,
  output logic [3:0] ch,
  output logic [7:0] d1,
  output logic [7:0] d2
);

  parse_state_e state_r, state_s;
  logic [7:0]   status_r, status_s;
  logic [7:0]   d1_r, d1_s;
  logic         one_byte_s;

  assign one_byte_s = (status_r[7:4] == 4'hC) || (status_r[7:4] == 4'hD);

  // Parser state, running status and first data byte.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r  <= IDLE;
      status_r <= 8'h00;
      d1_r     <= 8'h00;
    end else begin
      state_r  <= state_s;
      status_r <= status_s;
      d1_r     <= d1_s;
    end
  end

  // Next-state decode; realtime bytes (F8..FF) leave everything untouched.
  always_comb begin
    state_s   = state_r;
    status_s  = status_r;
    d1_s      = d1_r;
    msg_valid = 1'b0;
    msg_type  = status_r[7:4];
    ch        = status_r[3:0];
    d1        = d1_r;
    d2        = 8'h00;
    if (!byte_valid || (midi_byte >= 8'hF8)) begin
      state_s = state_r;
    end else if (midi_byte == 8'hF0) begin
      state_s = SYSEX;
    end else if (midi_byte >= 8'hF1) begin
      state_s = IDLE;
    end else if (midi_byte[7]) begin
      status_s = midi_byte;
      state_s  = DATA1;
    end else begin
      case (state_r)
        DATA1: begin
          if (one_byte_s) begin
            msg_valid = 1'b1;
            d1        = midi_byte;
          end else begin
            d1_s    = midi_byte;
            state_s = DATA2;
          end
        end
        DATA2: begin
          msg_valid = 1'b1;
          d2        = midi_byte;
          state_s   = DATA1;
        end
        default: state_s = state_r;
      endcase
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI voice allocator: channel filter, note-to-voice allocation with an age
// queue for stealing, sustain pedal and controller / program / bend decoding.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int VOICES       = 8,
  parameter int V_WIDTH      = clogb2(VOICES),
  parameter int OMNI         = 1,
  parameter int MIDI_CH      = 0,
  parameter int STEAL_OLDEST = 1
) (
  input  logic                    CLOCK_25,
  input  logic                    iRST_N,
  input  logic                    byte_valid,
  input  logic [7:0]              midi_byte,
  input  logic [VOICES-1:0]       voice_free_,
  output logic [VOICES-1:0]       key_on,
  output logic [VOICES-1:0][7:0]  key_val,
  output logic [VOICES-1:0][7:0]  vel_on,
  output logic                    ctrl_cmd,
  output logic [7:0]              ctrl_num,
  output logic [7:0]              ctrl_data,
  output logic                    prg_cmd,
  output logic [7:0]              prg_data,
  output logic                    pitch_cmd,
  output logic [13:0]             pitch_bend,
  output logic [V_WIDTH:0]        active_keys,
  output logic                    steal_event,
  output logic                    off_note_error
);

  localparam logic [V_WIDTH:0] ONE_W = (V_WIDTH+1)'(1);

  logic                   msg_valid, accept_s;
  logic [3:0]             msg_type, msg_ch;
  logic [7:0]             msg_d1, msg_d2;

  logic [VOICES-1:0]      free_r;
  logic [VOICES-1:0]      key_on_r, key_on_s, held_r, held_s;
  logic [VOICES-1:0][7:0] key_val_r, key_val_s, vel_r, vel_s;
  logic [V_WIDTH-1:0]     q_r [VOICES];
  logic [V_WIDTH-1:0]     q_s [VOICES];
  logic [VOICES-1:0]      q_vld_r, q_vld_s;
  logic                   sustain_r, sustain_s, off_err_r, off_err_s;
  logic                   ctrl_cmd_r, ctrl_cmd_s, prg_cmd_r, prg_cmd_s;
  logic                   pitch_cmd_r, pitch_cmd_s, steal_r, steal_s;
  logic [7:0]             ctrl_num_r, ctrl_num_s, ctrl_data_r, ctrl_data_s;
  logic [7:0]             prg_data_r, prg_data_s;
  logic [13:0]            pitch_r, pitch_s;
  logic [V_WIDTH:0]       active_r, active_s, w_s;
  logic                   hit_s, idle_s, rel_s, mv_en_s, keep_s;
  logic [V_WIDTH-1:0]     hit_idx_s, idle_idx_s, rel_idx_s, mv_idx_s;

  midi_byte_parser u_parser (
    .CLOCK_25   (CLOCK_25),
    .iRST_N     (iRST_N),
    .byte_valid (byte_valid),
    .midi_byte  (midi_byte),
    .msg_valid  (msg_valid),
    .msg_type   (msg_type),
    .ch         (msg_ch),
    .d1         (msg_d1),
    .d2         (msg_d2)
  );

  assign accept_s = msg_valid && ((OMNI != 0) || (msg_ch == 4'(MIDI_CH)));

  // Message execution and age-queue rebuild.
  always_comb begin
    key_on_s    = key_on_r;
    key_val_s   = key_val_r;
    vel_s       = vel_r;
    held_s      = held_r;
    sustain_s   = sustain_r;
    off_err_s   = off_err_r;
    ctrl_cmd_s  = 1'b0;
    ctrl_num_s  = ctrl_num_r;
    ctrl_data_s = ctrl_data_r;
    prg_cmd_s   = 1'b0;
    prg_data_s  = prg_data_r;
    pitch_cmd_s = 1'b0;
    pitch_s     = pitch_r;
    steal_s     = 1'b0;
    mv_en_s     = 1'b0;
    mv_idx_s    = '0;
    hit_s       = 1'b0;
    hit_idx_s   = '0;
    idle_s      = 1'b0;
    idle_idx_s  = '0;
    rel_s       = 1'b0;
    rel_idx_s   = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = VOICES - 1; i >= 0; i--) begin
      hit_idx_s  = (key_val_r[i] == msg_d1) ? V_WIDTH'(i) : hit_idx_s;
      hit_s      = hit_s | (key_val_r[i] == msg_d1);
      idle_idx_s = (!key_on_r[i] && free_r[i]) ? V_WIDTH'(i) : idle_idx_s;
      idle_s     = idle_s | (!key_on_r[i] && free_r[i]);
      rel_idx_s  = (!key_on_r[i]) ? V_WIDTH'(i) : rel_idx_s;
      rel_s      = rel_s | !key_on_r[i];
    end

    if (accept_s) begin
      case (msg_type)
        NOTE_ON, NOTE_OFF: begin
          if ((msg_type == NOTE_ON) && (msg_d2 != 8'd0)) begin
            if (hit_s) begin
              mv_en_s  = 1'b1;
              mv_idx_s = hit_idx_s;
            end else if (idle_s) begin
              mv_en_s  = 1'b1;
              mv_idx_s = idle_idx_s;
            end else if (rel_s) begin
              mv_en_s  = 1'b1;
              mv_idx_s = rel_idx_s;
            end else if (STEAL_OLDEST != 0) begin
              mv_en_s  = 1'b1;
              mv_idx_s = q_r[0];
              steal_s  = 1'b1;
            end else begin
              steal_s = 1'b1;
            end
            if (mv_en_s) begin
              key_on_s[mv_idx_s]  = 1'b1;
              key_val_s[mv_idx_s] = msg_d1;
              vel_s[mv_idx_s]     = msg_d2;
              held_s[mv_idx_s]    = 1'b0;
            end else begin
              held_s = held_r;
            end
          end else if (!hit_s) begin
            off_err_s = 1'b1;
          end else if (sustain_r) begin
            held_s[hit_idx_s] = 1'b1;
          end else begin
            key_on_s[hit_idx_s]  = 1'b0;
            key_val_s[hit_idx_s] = NO_NOTE;
            vel_s[hit_idx_s]     = msg_d2;
            held_s[hit_idx_s]    = 1'b0;
          end
        end
        CC: begin
          ctrl_cmd_s  = 1'b1;
          ctrl_num_s  = msg_d1;
          ctrl_data_s = msg_d2;
          if (msg_d1 == CC_SUSTAIN) begin
            sustain_s = (msg_d2 >= 8'd64);
            if (msg_d2 < 8'd64) begin
              for (int i = 0; i < VOICES; i++) begin
                key_on_s[i]  = key_on_r[i] & ~held_r[i];
                key_val_s[i] = held_r[i] ? NO_NOTE : key_val_r[i];
              end
              held_s = '0;
            end else begin
              held_s = held_r;
            end
          end else if ((msg_d1 == CC_SOUND_OFF) || (msg_d1 == CC_NOTES_OFF)) begin
            key_on_s  = '0;
            key_val_s = {VOICES{NO_NOTE}};
            held_s    = '0;
            off_err_s = (msg_d1 == CC_NOTES_OFF) ? 1'b0 : off_err_r;
          end else begin
            held_s = held_r;
          end
        end
        PRG: begin
          prg_cmd_s  = 1'b1;
          prg_data_s = msg_d1;
        end
        BEND: begin
          pitch_cmd_s = 1'b1;
          pitch_s     = {msg_d2[6:0], msg_d1[6:0]};
        end
        default: steal_s = 1'b0;
      endcase
    end else begin
      steal_s = 1'b0;
    end

    // Compact surviving entries (oldest first), then append the moved voice as youngest.
    q_s     = '{default: '0};
    q_vld_s = '0;
    w_s     = '0;
    keep_s  = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      keep_s = q_vld_r[i] && key_on_s[q_r[i]] && !(mv_en_s && (q_r[i] == mv_idx_s));
      if (keep_s) begin
        q_s[w_s[V_WIDTH-1:0]]     = q_r[i];
        q_vld_s[w_s[V_WIDTH-1:0]] = 1'b1;
        w_s                       = w_s + ONE_W;
      end else begin
        w_s = w_s;
      end
    end
    if (mv_en_s) begin
      q_s[w_s[V_WIDTH-1:0]]     = mv_idx_s;
      q_vld_s[w_s[V_WIDTH-1:0]] = 1'b1;
    end else begin
      q_vld_s = q_vld_s;
    end

    active_s = '0;
    for (int i = 0; i < VOICES; i++) begin
      active_s = active_s + (V_WIDTH+1)'(key_on_s[i]);
    end
  end

  // Architectural state registers.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      free_r      <= '0;
      key_on_r    <= '0;
      key_val_r   <= {VOICES{NO_NOTE}};
      vel_r       <= '0;
      held_r      <= '0;
      q_r         <= '{default: '0};
      q_vld_r     <= '0;
      sustain_r   <= 1'b0;
      off_err_r   <= 1'b0;
      ctrl_cmd_r  <= 1'b0;
      ctrl_num_r  <= 8'h00;
      ctrl_data_r <= 8'h00;
      prg_cmd_r   <= 1'b0;
      prg_data_r  <= 8'h00;
      pitch_cmd_r <= 1'b0;
      pitch_r     <= 14'h2000;
      active_r    <= '0;
      steal_r     <= 1'b0;
    end else begin
      free_r      <= voice_free_;
      key_on_r    <= key_on_s;
      key_val_r   <= key_val_s;
      vel_r       <= vel_s;
      held_r      <= held_s;
      q_r         <= q_s;
      q_vld_r     <= q_vld_s;
      sustain_r   <= sustain_s;
      off_err_r   <= off_err_s;
      ctrl_cmd_r  <= ctrl_cmd_s;
      ctrl_num_r  <= ctrl_num_s;
      ctrl_data_r <= ctrl_data_s;
      prg_cmd_r   <= prg_cmd_s;
      prg_data_r  <= prg_data_s;
      pitch_cmd_r <= pitch_cmd_s;
      pitch_r     <= pitch_s;
      active_r    <= active_s;
      steal_r     <= steal_s;
    end
  end

  assign key_on         = key_on_r;
  assign key_val        = key_val_r;
  assign vel_on         = vel_r;
  assign ctrl_cmd       = ctrl_cmd_r;
  assign ctrl_num       = ctrl_num_r;
  assign ctrl_data      = ctrl_data_r;
  assign prg_cmd        = prg_cmd_r;
  assign prg_data       = prg_data_r;
  assign pitch_cmd      = pitch_cmd_r;
  assign pitch_bend     = pitch_r;
  assign active_keys    = active_r;
  assign steal_event    = steal_r;
  assign off_note_error = off_err_r;

endmodule
